// File: rtl/fifo_mst_sched.sv
// rtl/fifo_mst_sched.sv - round-robin FT600 multi-channel bus scheduler for fifo_mst_fsm
module fifo_mst_sched #(
  parameter int NUM_CH  = 4,
  parameter int GAP_CYC = 3,
  parameter int TMO_CYC = 1024
) (
  input  logic              fifoClk,
  input  logic              fifoRstn,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] slv_rxf_n,
  input  logic [NUM_CH-1:0] slv_txe_n,
  input  logic [NUM_CH-1:0] ep_full,
  input  logic [NUM_CH-1:0] ep_empty,
  input  logic              mem_rdy,
  input  logic              idle_st,
  input  logic              clr_err,
  output logic              grant,
  output logic              m_rd_wr,
  output logic [2:0]        t_ep_num,
  output logic              sched_busy,
  output logic              abort_pls,
  output logic              tmo_err
);

  localparam int NSLOT = 2 * NUM_CH;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_GRANT, S_BUSY, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  slot_q, slot_d;
  logic [2:0]  rr_q, rr_d;
  logic [3:0]  gap_q, gap_d;
  logic [15:0] wdog_q, wdog_d;
  logic [2:0]  ep_q, ep_d;
  logic        rw_q, rw_d;
  logic        abort_q, abort_d;
  logic        tmo_q, tmo_d;

  logic [NSLOT-1:0] req;
  logic [2:0]       win;
  logic [2:0]       idx;
  logic             found;

  // Even slots are master writes, odd slots master reads, for the same channel.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req[2*i]   = ch_en[i] & ~slv_txe_n[i] & ~ep_empty[i];
      req[2*i+1] = ch_en[i] & ~slv_rxf_n[i] & ~ep_full[i];
    end
  end

  always_comb begin
    win   = rr_q;
    idx   = rr_q;
    found = 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      idx = rr_q + 3'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    wdog_d  = wdog_q;
    ep_d    = ep_q;
    rw_d    = rw_q;
    abort_d = 1'b0;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (mem_rdy && idle_st && (|req)) begin
          slot_d  = win;
          rw_d    = win[0];
          ep_d    = {1'b0, win[2:1]} + 3'd1;
          state_d = S_ARB;
        end
      end
      S_ARB: state_d = S_GRANT;
      S_GRANT: begin
        // Acceptance by the FSM takes priority over a withdrawn request.
        if (!idle_st) begin
          rr_d    = slot_q + 3'd1;
          wdog_d  = '0;
          state_d = S_BUSY;
        end else if (!req[slot_q]) begin
          abort_d = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_BUSY: begin
        if (idle_st) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else if (wdog_q != 16'(TMO_CYC - 1)) begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q == 4'(GAP_CYC - 1)) begin
          ep_d    = '0;
          rw_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_err) tmo_d = 1'b0;
    if (state_q == S_BUSY && wdog_q == 16'(TMO_CYC - 1)) tmo_d = 1'b1;
  end

  always_ff @(posedge fifoClk or negedge fifoRstn) begin
    if (!fifoRstn) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      wdog_q  <= '0;
      ep_q    <= '0;
      rw_q    <= 1'b0;
      abort_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      wdog_q  <= wdog_d;
      ep_q    <= ep_d;
      rw_q    <= rw_d;
      abort_q <= abort_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant      = (state_q == S_GRANT);
  assign sched_busy = (state_q != S_IDLE);
  assign m_rd_wr    = rw_q;
  assign t_ep_num   = ep_q;
  assign abort_pls  = abort_q;
  assign tmo_err    = tmo_q;

endmodule

// File: doc/fifo_mst_sched.md
Name: fifo_mst_sched

Overview:
Multi-channel bus scheduler for the FT600 FIFO master in 245/600 multi-channel mode.
- Collects per-channel read and write readiness from the FT600 slave status flags and the local endpoint buffer flags.
- Picks one transaction by round-robin over 8 slots (4 channels x 2 directions).
- Hands grant, direction and endpoint number to fifo_mst_fsm, then sequences the bus through its idle/busy/settle phases.
- Replaces the single-endpoint fifo_mst_arb when four endpoint buffers share the one FIFO bus.

Parameters:
NUM_CH, 4, number of channels; fixed at 4, slot count is 2*NUM_CH.
GAP_CYC, 3, settle cycles after each transaction before re-arbitration; allows for FT600 status-flag lag; legal range 1..15.
TMO_CYC, 1024, watchdog limit in cycles for the fifo_mst_fsm busy phase; legal range 16..65535.

Ports:
fifoClk  in  1  FIFO clock; all logic on the rising edge.
fifoRstn  in  1  asynchronous active-low reset.
ch_en  in  4  per-channel enable; 0 masks both directions of that channel.
slv_rxf_n  in  4  FT600 RXF_N per channel; 0 = slave has data for the master.
slv_txe_n  in  4  FT600 TXE_N per channel; 0 = slave can accept data.
ep_full  in  4  endpoint buffer full, per channel.
ep_empty  in  4  endpoint buffer empty, per channel.
mem_rdy  in  1  buffer RAM ready.
idle_st  in  1  fifo_mst_fsm is in idle state.
clr_err  in  1  synchronous clear of tmo_err.
grant  out  1  transaction grant to fifo_mst_fsm.
m_rd_wr  out  1  1 = master read (FT600 to buffer), 0 = master write.
t_ep_num  out  3  granted endpoint, 1-based (channel i -> i+1); 0 when no grant is latched.
sched_busy  out  1  high in every state except IDLE.
abort_pls  out  1  one-cycle pulse when a grant is withdrawn.
tmo_err  out  1  sticky watchdog error.

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr 0; gap and watchdog counters 0.
- Reset is asynchronous and may assert in any state: next state is IDLE, nothing is preserved.
- Request vector req[7:0], recomputed every cycle:
  - write slot 2i: ch_en[i] & ~slv_txe_n[i] & ~ep_empty[i].
  - read slot 2i+1: ch_en[i] & ~slv_rxf_n[i] & ~ep_full[i].
- Round-robin: winner is the first set bit of req scanning upward from rr_ptr, wrapping 7 -> 0.
- IDLE:
  - If mem_rdy & idle_st & |req, latch the winner slot and go to ARB.
  - Otherwise stay in IDLE.
- ARB (1 cycle):
  - Drive m_rd_wr = slot[0] and t_ep_num = slot[2:1] + 1.
  - Both outputs stay stable until the next IDLE.
  - Go to GRANT.
- GRANT:
  - grant = 1.
  - If idle_st = 0: grant accepted. Set rr_ptr = slot + 1 (mod 8), clear grant, go to BUSY.
  - Else if req[slot] = 0 (latched request withdrawn): clear grant, pulse abort_pls, leave rr_ptr unchanged, go to GAP.
  - If both occur in the same cycle, acceptance wins.
- BUSY:
  - Watchdog counts up from 0.
  - When idle_st = 1, go to GAP.
  - When the count reaches TMO_CYC - 1, set tmo_err and stay in BUSY; never force the FSM.
- GAP:
  - Count GAP_CYC cycles, then go to IDLE and clear t_ep_num and m_rd_wr to 0.
- Latency: req seen in IDLE at cycle N gives grant high at N+2 (N+1 is ARB). Minimum spacing between grants is 4 + GAP_CYC cycles.
- tmo_err: set by the watchdog; cleared by clr_err or reset. A set in the same cycle as clr_err wins.
- Request changes during ARB, BUSY and GAP are ignored. Only the latched slot matters.
- mem_rdy low only blocks IDLE -> ARB. It has no effect in the other states.

Test Plan:
- Reset mid-BUSY (t_ep_num = 3) -> next edge: state IDLE, grant/t_ep_num/sched_busy = 0, rr_ptr = 0.
- All 8 slots requesting continuously, FSM drops idle_st 1 cycle after grant and raises it 5 cycles later -> grant order is slots 0..7 then 0 again, i.e. (ep, rd_wr) = (1,0), (1,1), (2,0), (2,1), ...; spacing 4 + GAP_CYC + 5 cycles.
- Only slot 5 (ch2 read) requesting, rr_ptr = 6 -> wraps and grants with t_ep_num = 3, m_rd_wr = 1, grant at N+2.
- In GRANT, ep_full[1] rises with idle_st still 1, latched slot 3 -> abort_pls for 1 cycle, grant drops, GAP, rr_ptr still 3.
- idle_st held 0 for 1100 cycles (TMO_CYC = 1024) -> tmo_err set at BUSY cycle 1023, state stays BUSY; idle_st rises -> GAP then IDLE; clr_err pulse -> tmo_err = 0.
- ch_en = 4'b0010 with all flags ready; then mem_rdy = 0 -> only t_ep_num = 2 is granted; while mem_rdy = 0 the block stays in IDLE with no grant.
